sprite_line_reader: RTL

- Read-side engine for the sprite VRAM; counterpart to the 16-word write packer.
- Accepts a sprite-line request and drives the VRAM line address.
- Captures the 256-bit line and serialises it as a valid/ready pixel stream into the sprite compositor.
- Supports horizontal flip and synchronous flush for scanline aborts.

---
 rtl/sprite_pkg.sv | 10 +
 rtl/sprite_pixel_mux.sv | 16 +
 rtl/sprite_line_reader.sv | 72 +++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sizes, types and read-engine states for the sprite VRAM path
package sprite_pkg;
  localparam int SPRITE_ADDR_W  = 12;
  localparam int SPRITE_LINE_W  = 256;
  localparam int SPRITE_PIXEL_W = 8;
  localparam int SPRITE_NPIX    = SPRITE_LINE_W / SPRITE_PIXEL_W;
  typedef logic [SPRITE_PIXEL_W-1:0] sprite_pixel_t;
  typedef logic [SPRITE_LINE_W-1:0]  sprite_line_t;
  typedef enum logic [1:0] {IDLE, FETCH, STREAM} sprite_rd_state_e;
endpackage

// File: rtl/sprite_pixel_mux.sv
// sprite_pixel_mux: picks pixel k of a line, MSB-first normally, LSB-first when flipped
module sprite_pixel_mux import sprite_pkg::*; #(
  parameter int LINE_W  = SPRITE_LINE_W,
  parameter int PIXEL_W = SPRITE_PIXEL_W,
  localparam int CW     = $clog2(LINE_W / PIXEL_W)
) (
  input  logic [LINE_W-1:0]  line_i,
  input  logic [CW-1:0]      cnt_i,
  input  logic               hflip_i,
  output logic [PIXEL_W-1:0] pixel_o
);
  logic [CW-1:0] idx;
  // unflipped slot k sits at byte position NPIX-1-k, which is ~k
  assign idx     = hflip_i ? cnt_i : ~cnt_i;
  assign pixel_o = line_i[int'(idx) * PIXEL_W +: PIXEL_W];
endmodule

// File: rtl/sprite_line_reader.sv
// sprite_line_reader: fetches one VRAM sprite line and streams it as valid/ready pixels
module sprite_line_reader import sprite_pkg::*; #(
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int LINE_W  = SPRITE_LINE_W,
  parameter int PIXEL_W = SPRITE_PIXEL_W,
  parameter int NPIX    = LINE_W / PIXEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_hflip,
  input  logic               flush,
  output logic [ADDR_W-1:0]  read_addr,
  input  logic [LINE_W-1:0]  read_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIXEL_W-1:0] pix_data,
  output logic               pix_last
);
  localparam int CW = $clog2(NPIX);
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);
  sprite_rd_state_e   state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               hflip_q;
  logic [LINE_W-1:0]  line_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PIXEL_W-1:0] pixel;
  assign cnt_d = cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hflip_q <= 1'b0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          hflip_q <= req_hflip;
          state_q <= FETCH;
        end
        FETCH: begin
          line_q  <= read_data;
          cnt_q   <= '0;
          state_q <= STREAM;
        end
        STREAM: if (pix_ready) begin
          cnt_q   <= cnt_d;
          state_q <= (cnt_q == LAST) ? IDLE : STREAM;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  sprite_pixel_mux #(.LINE_W(LINE_W), .PIXEL_W(PIXEL_W)) u_mux (
    .line_i (line_q),
    .cnt_i  (cnt_q),
    .hflip_i(hflip_q),
    .pixel_o(pixel)
  );
  assign req_ready = state_q == IDLE;
  assign pix_valid = state_q == STREAM;
  assign read_addr = addr_q;
  assign pix_data  = pix_valid ? pixel : '0;
  assign pix_last  = pix_valid && (cnt_q == LAST);
endmodule
